// File: rtl/programmable_ce_divider.sv
`default_nettype none
// programmable_ce_divider: multi-channel runtime-programmable clock-enable generator
// with periodic and retriggerable one-shot modes. Revision 1.0

module programmable_ce_divider #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 17,
  parameter int DEFAULT_DIV = 100000,
  localparam int AW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic                WE,
  input  logic [AW-1:0]       WADDR,
  input  logic [WIDTH-1:0]    WDATA,
  input  logic [CHANNELS-1:0] CH_EN,
  input  logic [CHANNELS-1:0] ONESHOT,
  input  logic [CHANNELS-1:0] START,
  output logic [CHANNELS-1:0] CEO,
  output logic [CHANNELS-1:0] BUSY
);

  localparam logic [WIDTH-1:0] DIV_RESET = WIDTH'(DEFAULT_DIV);
  localparam logic [AW:0]      NUM_CH    = (AW + 1)'(CHANNELS);

  logic write_ok;
  assign write_ok = WE && ({1'b0, WADDR} < NUM_CH);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] tc;
    logic             ceo;
    logic             busy;
    logic             was_periodic;
    logic             wr_hit;
    logic             at_tc;

    assign tc     = (div == '0) ? '0 : div - WIDTH'(1);
    assign at_tc  = (cnt == tc);
    assign wr_hit = write_ok && (WADDR == AW'(i));

    // In one-shot mode BUSY doubles as the RUN state; was_periodic catches the
    // periodic-to-one-shot switch so the channel drops to IDLE instead of running on.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        div          <= DIV_RESET;
        cnt          <= '0;
        ceo          <= 1'b0;
        busy         <= 1'b0;
        was_periodic <= 1'b0;
      end else if (wr_hit) begin
        div <= WDATA;
        cnt <= '0;
        ceo <= 1'b0;
      end else if (!CH_EN[i]) begin
        cnt          <= '0;
        ceo          <= 1'b0;
        busy         <= 1'b0;
        was_periodic <= 1'b0;
      end else if (!EN) begin
        ceo <= 1'b0;
      end else begin
        was_periodic <= !ONESHOT[i];
        if (!ONESHOT[i]) begin
          busy <= 1'b1;
          if (at_tc) begin
            cnt <= '0;
            ceo <= 1'b1;
          end else begin
            cnt <= cnt + WIDTH'(1);
            ceo <= 1'b0;
          end
        end else if (was_periodic) begin
          cnt  <= '0;
          ceo  <= 1'b0;
          busy <= 1'b0;
        end else if (START[i]) begin
          cnt  <= '0;
          ceo  <= 1'b0;
          busy <= 1'b1;
        end else if (busy) begin
          if (at_tc) begin
            cnt  <= '0;
            ceo  <= 1'b1;
            busy <= 1'b0;
          end else begin
            cnt <= cnt + WIDTH'(1);
            ceo <= 1'b0;
          end
        end else begin
          cnt <= '0;
          ceo <= 1'b0;
        end
      end
    end

    assign CEO[i]  = ceo;
    assign BUSY[i] = busy;
  end

endmodule

`default_nettype wire

// File: tb/tb_programmable_ce_divider.sv
`default_nettype none
// tb_programmable_ce_divider: directed, table-driven bench for programmable_ce_divider
// (3 channels, short default divisor). Revision 1.0

module tb_programmable_ce_divider;

  localparam int CH = 3;
  localparam int W  = 17;
  localparam int DD = 20;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          EN;
  logic          WE;
  logic [1:0]    WADDR;
  logic [W-1:0]  WDATA;
  logic [CH-1:0] CH_EN;
  logic [CH-1:0] ONESHOT;
  logic [CH-1:0] START;
  logic [CH-1:0] CEO;
  logic [CH-1:0] BUSY;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic          we;
    logic [1:0]    waddr;
    logic [W-1:0]  wdata;
    logic [CH-1:0] ch_en;
    logic [CH-1:0] oneshot;
    logic [CH-1:0] start;
    logic          en;
    logic [CH-1:0] ceo;
    logic [CH-1:0] busy;
  } vec_t;

  vec_t vecs[$];

  programmable_ce_divider #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .DEFAULT_DIV (DD)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .EN      (EN),
    .WE      (WE),
    .WADDR   (WADDR),
    .WDATA   (WDATA),
    .CH_EN   (CH_EN),
    .ONESHOT (ONESHOT),
    .START   (START),
    .CEO     (CEO),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [CH-1:0] got, input logic [CH-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic row(input logic we, input logic [1:0] wa, input logic [W-1:0] wd,
                     input logic [CH-1:0] che, input logic [CH-1:0] os, input logic [CH-1:0] st,
                     input logic en, input logic [CH-1:0] ceo, input logic [CH-1:0] busy);
    vec_t r;
    r.we = we; r.waddr = wa; r.wdata = wd; r.ch_en = che; r.oneshot = os;
    r.start = st; r.en = en; r.ceo = ceo; r.busy = busy;
    vecs.push_back(r);
  endtask

  task automatic write(input logic [1:0] wa, input logic [W-1:0] wd);
    WE = 1'b1; WADDR = wa; WDATA = wd;
    tick();
    WE = 1'b0;
  endtask

  initial begin
    // One-shot table on channel 0 (DIV=4), channel 1 disabled.
    row(1, 0, 4, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b001); // write keeps BUSY
    row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b000); // periodic->one-shot: IDLE
    row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b000);
    row(0, 0, 0, 3'b001, 3'b001, 3'b001, 1, 3'b000, 3'b001); // START
    for (int k = 0; k < 3; k++) row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b001);
    row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b001, 3'b000); // single CEO, BUSY drops
    for (int k = 0; k < 2; k++) row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b000);
    row(0, 0, 0, 3'b001, 3'b001, 3'b001, 1, 3'b000, 3'b001); // START
    for (int k = 0; k < 2; k++) row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b001);
    row(0, 0, 0, 3'b001, 3'b001, 3'b001, 1, 3'b000, 3'b001); // retrigger at count 2
    for (int k = 0; k < 3; k++) row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b001);
    row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b001, 3'b000);
    row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b000);
    row(0, 0, 0, 3'b001, 3'b001, 3'b001, 1, 3'b000, 3'b001); // START
    for (int k = 0; k < 3; k++) row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b001);
    row(0, 0, 0, 3'b001, 3'b001, 3'b001, 1, 3'b000, 3'b001); // retrigger at TC: no CEO
    for (int k = 0; k < 3; k++) row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b001);
    row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b001, 3'b000);
    row(0, 0, 0, 3'b001, 3'b001, 3'b001, 1, 3'b000, 3'b001); // START
    row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b001);
    row(0, 0, 0, 3'b000, 3'b001, 3'b000, 1, 3'b000, 3'b000); // CH_EN drop aborts
    row(0, 0, 0, 3'b000, 3'b001, 3'b001, 1, 3'b000, 3'b000); // START ignored
    for (int k = 0; k < 5; k++) row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b000);
    row(0, 0, 0, 3'b001, 3'b001, 3'b001, 0, 3'b000, 3'b000); // START ignored while EN=0
    row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b000);
    row(0, 0, 0, 3'b001, 3'b001, 3'b001, 1, 3'b000, 3'b001); // START
    row(0, 0, 0, 3'b001, 3'b001, 3'b000, 1, 3'b000, 3'b001);
    row(0, 0, 0, 3'b001, 3'b000, 3'b000, 1, 3'b000, 3'b001); // to periodic, keeps counting
    row(0, 0, 0, 3'b001, 3'b000, 3'b000, 1, 3'b000, 3'b001);
    row(0, 0, 0, 3'b001, 3'b000, 3'b000, 1, 3'b001, 3'b001);
    for (int k = 0; k < 3; k++) row(0, 0, 0, 3'b001, 3'b000, 3'b000, 1, 3'b000, 3'b001);
    row(0, 0, 0, 3'b001, 3'b000, 3'b000, 1, 3'b001, 3'b001);

    // Reset state
    RST_N = 1'b0; EN = 1'b0; WE = 1'b0; WADDR = '0; WDATA = '0;
    CH_EN = '0; ONESHOT = '0; START = '0;
    repeat (3) tick();
    check("reset_ceo", CEO, 3'b000);
    check("reset_busy", BUSY, 3'b000);

    // Default divisor, periodic, both channels aligned
    CH_EN = 3'b011; EN = 1'b1;
    RST_N = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      check($sformatf("dflt_ceo[%0d]", k), CEO, (k % DD == 0) ? 3'b011 : 3'b000);
      check($sformatf("dflt_busy[%0d]", k), BUSY, 3'b011);
    end

    // Divisor write 5 to channel 1 mid-count (ch0 count is 7)
    repeat (7) tick();
    write(2'd1, 17'd5);
    check("wr5_edge_ceo", CEO, 3'b000);
    for (int m = 1; m <= 15; m++) begin
      tick();
      check($sformatf("wr5_ceo[%0d]", m), CEO,
            {1'b0, (m % 5 == 0) ? 1'b1 : 1'b0, (m == 12) ? 1'b1 : 1'b0});
    end

    // DIV=0 and DIV=1 both give a continuous strobe
    write(2'd1, 17'd0);
    check("wr0_edge_ceo1", {2'b00, CEO[1]}, 3'b000);
    for (int m = 1; m <= 4; m++) begin
      tick();
      check($sformatf("div0_ceo1[%0d]", m), {2'b00, CEO[1]}, 3'b001);
    end
    write(2'd1, 17'd1);
    check("wr1_edge_ceo1", {2'b00, CEO[1]}, 3'b000);
    for (int m = 1; m <= 4; m++) begin
      tick();
      check($sformatf("div1_ceo1[%0d]", m), {2'b00, CEO[1]}, 3'b001);
    end

    // Out-of-range address: no side effects
    write(2'd3, 17'd2);
    check("oor_edge_ceo1", {2'b00, CEO[1]}, 3'b001);
    for (int m = 1; m <= 4; m++) begin
      tick();
      check($sformatf("oor_ceo1[%0d]", m), {2'b00, CEO[1]}, 3'b001);
    end

    // EN freeze: ch0 DIV=8 at count 3, frozen 10 cycles
    write(2'd0, 17'd8);
    for (int m = 1; m <= 3; m++) begin
      tick();
      check($sformatf("pre_frz_ceo0[%0d]", m), {2'b00, CEO[0]}, 3'b000);
    end
    EN = 1'b0;
    for (int m = 1; m <= 10; m++) begin
      tick();
      check($sformatf("frz_ceo[%0d]", m), CEO, 3'b000);
      check($sformatf("frz_busy[%0d]", m), BUSY, 3'b011);
    end
    EN = 1'b1;
    for (int n = 1; n <= 13; n++) begin
      tick();
      check($sformatf("thaw_ceo0[%0d]", n), {2'b00, CEO[0]},
            (n == 5 || n == 13) ? 3'b001 : 3'b000);
    end

    // One-shot vector table
    foreach (vecs[i]) begin
      WE = vecs[i].we; WADDR = vecs[i].waddr; WDATA = vecs[i].wdata;
      CH_EN = vecs[i].ch_en; ONESHOT = vecs[i].oneshot; START = vecs[i].start;
      EN = vecs[i].en;
      tick();
      check($sformatf("tbl_ceo[%0d]", i), CEO, vecs[i].ceo);
      check($sformatf("tbl_busy[%0d]", i), BUSY, vecs[i].busy);
    end
    WE = 1'b0; START = '0; EN = 1'b1;

    // Asynchronous reset mid-cycle while CEO[1] is high
    CH_EN = 3'b011; ONESHOT = 3'b000;
    tick();
    tick();
    check("pre_rst_ceo1", {2'b00, CEO[1]}, 3'b001);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_ceo", CEO, 3'b000);
    check("async_rst_busy", BUSY, 3'b000);
    tick();
    tick();
    RST_N = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      check($sformatf("post_rst_ceo[%0d]", k), CEO, (k % DD == 0) ? 3'b011 : 3'b000);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
